// File: rtl/ahbl_excl_sram.sv
// ---------------------------------------------------------------------------
// ahbl_excl_sram
//   AHB-Lite SRAM responder with an exclusive-access monitor, sitting behind
//   an N:1 arbiter. Reads and writes are zero-wait. The one exception is a
//   read whose address phase targets the word being written in the current
//   data phase: that read gets one wait state so it returns the post-write
//   word. Out-of-range or misaligned accesses get the two-cycle ERROR
//   response and change nothing.
//
//   Handshake: an address phase is accepted when ahbls_hready=1 and
//   ahbls_htrans[1]=1. Its data phase completes in the first cycle in which
//   ahbls_hready_resp=1. ahbls_hrdata, ahbls_hresp and ahbls_hexokay are
//   meaningful only in that completing cycle, except that ahbls_hresp is
//   also high in the first ERROR cycle.
//
//   Ports
//     clk, rst             clock, asynchronous active-high reset
//     ahbls_hready         bus-level HREADY
//     ahbls_hready_resp    slave ready
//     ahbls_hresp          1 = ERROR
//     ahbls_haddr/hwrite/htrans/hsize  address-phase controls
//     ahbls_hburst/hprot/hmastlock     ignored
//     ahbls_hwdata         write data (data phase)
//     ahbls_hrdata         read data (data phase)
//     ahbls_hexcl          exclusive-access request
//     ahbls_hmaster        master ID; low bits select the monitor entry
//     ahbls_hexokay        exclusive success
// ---------------------------------------------------------------------------
module ahbl_excl_sram #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32,
  parameter int DEPTH  = 1024,
  parameter int N_MON  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ahbls_hready,
  output logic              ahbls_hready_resp,
  output logic              ahbls_hresp,
  input  logic [W_ADDR-1:0] ahbls_haddr,
  input  logic              ahbls_hwrite,
  input  logic [1:0]        ahbls_htrans,
  input  logic [2:0]        ahbls_hsize,
  input  logic [2:0]        ahbls_hburst,
  input  logic [3:0]        ahbls_hprot,
  input  logic              ahbls_hmastlock,
  input  logic [W_DATA-1:0] ahbls_hwdata,
  output logic [W_DATA-1:0] ahbls_hrdata,
  input  logic              ahbls_hexcl,
  input  logic [7:0]        ahbls_hmaster,
  output logic              ahbls_hexokay
);

  localparam int IW = $clog2(DEPTH);
  localparam int MW = (N_MON > 1) ? $clog2(N_MON) : 1;
  localparam int NB = W_DATA / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_WAIT_RAW,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t state_q;
  logic   hready_resp_q;
  logic   hresp_q;

  // Registered address-phase controls
  logic [IW-1:0] idx_q;
  logic [1:0]    off_q;
  logic [2:0]    size_q;
  logic          write_q;
  logic          excl_q;
  logic [MW-1:0] mon_q;

  // Memory and read register (not reset)
  logic [W_DATA-1:0] mem [DEPTH];
  logic [W_DATA-1:0] rdata_q;

  // Exclusive monitor
  logic          mon_vld_q [N_MON];
  logic [IW-1:0] mon_idx_q [N_MON];

  // -------------------------------------------------------------------------
  // Address-phase decode
  // -------------------------------------------------------------------------
  logic          accept;
  logic [IW-1:0] idx_a;
  logic [MW-1:0] mon_a;
  logic          addr_hi;
  logic          misalign;
  logic          oor;

  // No accept in ERR1 or WAIT_RAW: our own hready_resp is low there.
  assign accept = ahbls_hready && ahbls_htrans[1] &&
                  (state_q == S_IDLE || state_q == S_DATA || state_q == S_ERR2);
  assign idx_a  = ahbls_haddr[IW+1:2];
  assign mon_a  = (N_MON > 1) ? ahbls_hmaster[MW-1:0] : '0;

  assign addr_hi = (ahbls_haddr >> (IW + 2)) != '0;

  always_comb begin
    misalign = 1'b0;
    case (ahbls_hsize)
      3'd1:    misalign = ahbls_haddr[0];
      3'd2:    misalign = |ahbls_haddr[1:0];
      default: misalign = 1'b0;
    endcase
  end

  assign oor = addr_hi || (ahbls_hsize > 3'd2) || misalign;

  // -------------------------------------------------------------------------
  // Data-phase decode
  // -------------------------------------------------------------------------
  logic          in_data;
  logic          excl_ok;
  logic          wr_en;
  logic          rd_accept;
  logic          hazard;
  logic          rd_en;
  logic [IW-1:0] rd_idx;
  logic          excl_set;
  logic [NB-1:0] be;

  assign in_data   = (state_q == S_DATA);
  assign excl_ok   = mon_vld_q[mon_q] && (mon_idx_q[mon_q] == idx_q);
  // A failed exclusive write performs no write.
  assign wr_en     = in_data && write_q && (!excl_q || excl_ok);
  assign rd_accept = accept && !oor && !ahbls_hwrite;
  // The read launched at this edge would see the pre-write word.
  assign hazard    = rd_accept && wr_en && (idx_a == idx_q);
  // WAIT_RAW re-reads the now-updated word using the read's registered index.
  assign rd_en     = rd_accept || (state_q == S_WAIT_RAW);
  assign rd_idx    = (state_q == S_WAIT_RAW) ? idx_q : idx_a;
  assign excl_set  = rd_accept && ahbls_hexcl;

  always_comb begin
    be = '0;
    case (size_q)
      3'd0:    be = NB'(1) << off_q;
      3'd1:    be = NB'(3) << off_q;
      default: be = '1;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM with registered response outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      hready_resp_q <= 1'b1;
      hresp_q       <= 1'b0;
      idx_q         <= '0;
      off_q         <= '0;
      size_q        <= '0;
      write_q       <= 1'b0;
      excl_q        <= 1'b0;
      mon_q         <= '0;
    end else begin
      case (state_q)
        S_ERR1: begin
          state_q       <= S_ERR2;
          hready_resp_q <= 1'b1;
          hresp_q       <= 1'b1;
        end
        S_WAIT_RAW: begin
          state_q       <= S_DATA;
          hready_resp_q <= 1'b1;
          hresp_q       <= 1'b0;
        end
        default: begin
          if (accept) begin
            idx_q   <= idx_a;
            off_q   <= ahbls_haddr[1:0];
            size_q  <= ahbls_hsize;
            write_q <= ahbls_hwrite;
            excl_q  <= ahbls_hexcl;
            mon_q   <= mon_a;
            if (oor) begin
              state_q       <= S_ERR1;
              hready_resp_q <= 1'b0;
              hresp_q       <= 1'b1;
            end else if (hazard) begin
              state_q       <= S_WAIT_RAW;
              hready_resp_q <= 1'b0;
              hresp_q       <= 1'b0;
            end else begin
              state_q       <= S_DATA;
              hready_resp_q <= 1'b1;
              hresp_q       <= 1'b0;
            end
          end else begin
            state_q       <= S_IDLE;
            hready_resp_q <= 1'b1;
            hresp_q       <= 1'b0;
          end
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Memory: byte-lane write at the end of the data phase, read launched
  // from the address phase
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) begin
          mem[idx_q][8*b +: 8] <= ahbls_hwdata[8*b +: 8];
        end
      end
    end
    if (rd_en) begin
      rdata_q <= mem[rd_idx];
    end
  end

  // -------------------------------------------------------------------------
  // Exclusive monitor. The set is written after the clear so that a
  // same-cycle exclusive read wins over a write's clear.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_MON; i++) begin
        mon_vld_q[i] <= 1'b0;
        mon_idx_q[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        for (int i = 0; i < N_MON; i++) begin
          if (mon_idx_q[i] == idx_q) begin
            mon_vld_q[i] <= 1'b0;
          end
        end
      end
      if (excl_set) begin
        mon_vld_q[mon_a] <= 1'b1;
        mon_idx_q[mon_a] <= idx_a;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign ahbls_hready_resp = hready_resp_q;
  assign ahbls_hresp       = hresp_q;
  assign ahbls_hrdata      = rdata_q;
  assign ahbls_hexokay     = in_data && excl_q && (!write_q || excl_ok);

  logic unused_inputs;
  assign unused_inputs = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock,
                           ahbls_hmaster, ahbls_htrans[0]};

endmodule
